// File: rtl/conv_feeder_pkg.sv
// Shared types and constants for the convolution row feeder.
package conv_feeder_pkg;

  localparam int RING_DEPTH         = 3;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_FLUSH
  } feeder_state_e;

endpackage

// File: rtl/conv_row_feeder_if.sv
// Row/window bus between the feeder (slave) and its environment (master): the
// row source plus the convolution consumer.
interface conv_row_feeder_if
  import conv_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int H          = 64
);

  logic [H*DATA_WIDTH-1:0] in_row;
  logic                    in_valid;
  logic                    in_ready;
  logic [H*DATA_WIDTH-1:0] image0;
  logic [H*DATA_WIDTH-1:0] image1;
  logic [H*DATA_WIDTH-1:0] image2;
  logic                    image_start;
  logic                    conv_done;
  logic                    frame_done;

  modport master (
    output in_row, in_valid, conv_done,
    input  in_ready, image0, image1, image2, image_start, frame_done
  );

  modport slave (
    input  in_row, in_valid, conv_done,
    output in_ready, image0, image1, image2, image_start, frame_done
  );

endinterface

// File: rtl/row_ring_buffer.sv
// Three-row circular store; exposes the two most recently written rows so the
// feeder can form a window together with the row arriving this cycle.
module row_ring_buffer
  import conv_feeder_pkg::*;
#(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic             clr_ptr_i,
  input  logic [ROW_W-1:0] wr_row_i,
  output logic [ROW_W-1:0] last_row_o,
  output logic [ROW_W-1:0] prev_row_o
);

  logic [ROW_W-1:0] mem_q [RING_DEPTH];
  logic [1:0]       wr_ptr_q;
  logic [1:0]       wr_ptr_d;

  always_comb begin
    // NOTE: assign the default first so every path drives wr_ptr_d and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    if (clr_ptr_i) begin
      wr_ptr_d = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = (wr_ptr_q == 2'(RING_DEPTH - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
    end
  end

  // NOTE: the storage is reset (not left uninitialised) so a discarded frame never leaks into the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RING_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_row_i;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_comb begin
    case (wr_ptr_q)
      2'd1: begin
        last_row_o = mem_q[0];
        prev_row_o = mem_q[2];
      end
      2'd2: begin
        last_row_o = mem_q[1];
        prev_row_o = mem_q[0];
      end
      default: begin
        last_row_o = mem_q[2];
        prev_row_o = mem_q[1];
      end
    endcase
  end

endmodule

// File: rtl/conv_row_feeder.sv
// Streams image rows into 3-row windows for a convolution engine.
// Define CONV_FEEDER_ZERO_PAD_EN to also issue the zero-padded top/bottom windows.
module conv_row_feeder
  import conv_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int H          = 64,
  parameter int W          = 64
) (
  input logic              clk,
  input logic              reset,
  conv_row_feeder_if.slave bus
);

  localparam int ROW_W = H * DATA_WIDTH;
  localparam int CW    = $clog2(W + 1);
`ifdef CONV_FEEDER_ZERO_PAD_EN
  localparam int FIRST_ISSUE_K = 1;
  localparam int WINDOWS       = W;
`else
  localparam int FIRST_ISSUE_K = 2;
  localparam int WINDOWS       = W - 2;
`endif
  localparam logic [CW-1:0] W_C       = CW'(W);
  localparam logic [CW-1:0] WIN_C     = CW'(WINDOWS);
  localparam logic [CW-1:0] ISSUE_K_C = CW'(FIRST_ISSUE_K);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  feeder_state_e    state_q;
  logic [CW-1:0]    rows_in_q;
  logic [CW-1:0]    rows_out_q;
  logic             in_ready_q;
  logic             image_start_q;
  logic             frame_done_q;
  logic [ROW_W-1:0] image0_q, image1_q, image2_q;
  logic [ROW_W-1:0] last_row, prev_row;
  logic             accept;
  logic             frame_end;

  assign accept    = bus.in_valid & in_ready_q;
  assign frame_end = (state_q == S_WAIT) && bus.conv_done &&
                     (rows_in_q == W_C) && (rows_out_q == WIN_C);

  row_ring_buffer #(.ROW_W(ROW_W)) u_ring (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (accept),
    .clr_ptr_i (frame_end),
    .wr_row_i  (bus.in_row),
    .last_row_o(last_row),
    .prev_row_o(prev_row)
  );

  // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rows_in_q     <= '0;
      rows_out_q    <= '0;
      in_ready_q    <= 1'b0;
      image_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      image0_q      <= '0;
      image1_q      <= '0;
      image2_q      <= '0;
    end else begin
      image_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            rows_in_q <= ONE_C;
            state_q   <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            rows_in_q <= rows_in_q + ONE_C;
            if (rows_in_q >= ISSUE_K_C) begin
              // The arriving row is the bottom of the window it completes.
`ifdef CONV_FEEDER_ZERO_PAD_EN
              image0_q <= (rows_in_q == ONE_C) ? '0 : prev_row;
`else
              image0_q <= prev_row;
`endif
              image1_q      <= last_row;
              image2_q      <= bus.in_row;
              image_start_q <= 1'b1;
              in_ready_q    <= 1'b0;
              state_q       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          rows_out_q <= rows_out_q + ONE_C;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.conv_done) begin
            if (rows_in_q < W_C) begin
              in_ready_q <= 1'b1;
              state_q    <= S_FILL;
            end else if (rows_out_q < WIN_C) begin
              state_q <= S_FLUSH;
            end else begin
              rows_in_q    <= '0;
              rows_out_q   <= '0;
              frame_done_q <= 1'b1;
              in_ready_q   <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          image0_q      <= prev_row;
          image1_q      <= last_row;
          image2_q      <= '0;
          image_start_q <= 1'b1;
          state_q       <= S_ISSUE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.image_start = image_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.image0      = image0_q;
  assign bus.image1      = image1_q;
  assign bus.image2      = image2_q;

endmodule

// File: doc/conv_row_feeder.md
CONV_ROW_FEEDER -- requirements
Module: conv_row_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per pixel word.
REQ-002 Parameter H, default 64, pixel words per image row.
REQ-003 Parameter W, default 64, rows per frame; W >= 3.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_row  input  H*DATA_WIDTH  incoming image row, word 0 in MSBs.
REQ-007 in_valid  input  1  in_row valid.
REQ-008 in_ready  output  1  feeder accepts in_row this cycle.
REQ-009 image0, image1, image2  output  H*DATA_WIDTH each  window rows above, centre and below.
REQ-010 image_start  output  1  one-cycle pulse; window rows valid from this cycle.
REQ-011 conv_done  input  1  consumer finished the current window.
REQ-012 frame_done  output  1  one-cycle pulse after the last window of a frame completes.

Function
REQ-013 A row transfers on a rising edge with in_valid=1 and in_ready=1; no other transfer exists.
REQ-014 Rows go into a 3-entry ring buffer; write pointer wraps 2->0; rows_in counts 0..W.
REQ-015 FSM states: IDLE, FILL, ISSUE, WAIT, FLUSH.
REQ-016 IDLE: in_ready=1; the first accepted row goes to FILL with rows_in=1.
REQ-017 FILL: in_ready=1; each accepted row goes to ISSUE.
REQ-018 ISSUE: lasts one cycle, image_start=1, in_ready=0, then goes to WAIT.
REQ-019 WAIT: in_ready=0; image0/1/2 held stable; conv_done=1 goes to FILL if rows_in<W, else FLUSH (if a final window is pending) or IDLE.
REQ-020 FLUSH: issues the bottom edge window (image0=row W-2, image1=row W-1, image2=0) via ISSUE/WAIT, then IDLE.
REQ-021 Output row r is centred on input row r; rows -1 and W read as all-zero words.
REQ-022 Window r is issued in the cycle after row r+1 is accepted; the bottom window W-1 is issued from FLUSH.
REQ-023 frame_done pulses in the cycle after conv_done for the last window of a frame; rows_in, rows_out and pointers return to 0 in that cycle.
REQ-024 Latency: image_start asserts exactly 1 cycle after the accepting edge of the enabling row.
REQ-025 conv_done outside WAIT is ignored; in_valid during ISSUE/WAIT/FLUSH is back-pressured, never dropped.
REQ-026 conv_done arriving in the same cycle as image_start is ignored; at least one WAIT cycle is required.
REQ-027 Row data passes through unmodified; no arithmetic on pixel words.

Reset
REQ-028 Asserting reset at any time, including mid-frame, forces IDLE and clears counters and pointers; the partial frame is discarded.
REQ-029 Output values during reset: in_ready=0, image_start=0, frame_done=0, image0/1/2=0, buffer contents=0.
REQ-030 in_ready rises in the first clock after reset deasserts.

Configuration
REQ-031 Macro CONV_FEEDER_ZERO_PAD_EN defined: W windows per frame, including top and bottom zero-padded edge windows.
REQ-032 Macro absent: only interior windows 1..W-2 are issued (W-2 per frame); FLUSH is unreachable; outputs never contain padding zeros.

Structure
REQ-033 Package conv_feeder_pkg holds the FSM state enumeration, the ring depth constant 3 and the DATA_WIDTH default.
REQ-034 Sub-module row_ring_buffer holds the 3-entry storage and wrap pointer; the FSM, counters and window mux live in conv_row_feeder.

Verification
REQ-035 DATA_WIDTH=8, H=4, W=4, pad on; rows 0x01..,0x02..,0x03..,0x04.. with conv_done 2 cycles after each image_start -> 4 windows, first (0,R0,R1), last (R2,R3,0), 1 frame_done.
REQ-036 Same stimulus with the macro undefined -> exactly 2 windows, (R0,R1,R2) and (R1,R2,R3); no zero rows.
REQ-037 in_valid held high continuously -> in_ready=0 throughout each ISSUE/WAIT; every row accepted exactly once, in order.
REQ-038 conv_done pulses in IDLE and in the image_start cycle -> no state change and no extra window.
REQ-039 reset asserted in WAIT of window 2 -> all outputs 0 at once; the next frame starts cleanly with window 0 = (0,R0,R1).
REQ-040 Two back-to-back frames with W=4 -> ring pointer wraps correctly; 8 windows and 2 frame_done pulses.
